// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (port 0) and loader/DMA (port 1) share one memory.
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise port 0 always wins a tie.
`timescale 1ns/1ps

module dmem_arbiter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [10:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [1:0]  m0_lsHB_i,
   input  logic        m0_lU_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [10:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [1:0]  m1_lsHB_i,
   input  logic        m1_lU_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_rdata_o,
   output logic        cpu_stall_o,
   output logic        mem_rd_o,
   output logic        mem_wr_o,
   output logic [10:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [1:0]  mem_lsHB_o,
   output logic        mem_lU_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

`ifdef DMEM_ARB_RR_EN
   localparam logic RrEn = 1'b1;
`else
   localparam logic RrEn = 1'b0;
`endif

   state_t      state_q, state_d;
   logic        we_q, lU_q, lastGrant_q;
   logic [10:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  lsHB_q;
   logic        m0Ack_q, m1Ack_q;
   logic [31:0] m0Rdata_q, m1Rdata_q;

   logic        elig0, elig1, tieTo1, capture, grant1;

   // A port whose ack is showing this cycle is not re-granted on its still-held request.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      grant1  = 1'b0;
      elig0   = m0_req_i & ~m0Ack_q;
      elig1   = m1_req_i & ~m1Ack_q;
      tieTo1  = RrEn & ~lastGrant_q;
      case (state_q)
         IDLE: begin
            if (elig0 | elig1) begin
               capture = 1'b1;
               grant1  = elig1 & (~elig0 | tieTo1);
               state_d = grant1 ? ACC1 : ACC0;
            end
         end
         ACC0, ACC1: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Holding registers latch the granted request; acks and read data register on leaving ACCn.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lsHB_q      <= '0;
         lU_q        <= 1'b0;
         lastGrant_q <= 1'b1;
         m0Ack_q     <= 1'b0;
         m1Ack_q     <= 1'b0;
         m0Rdata_q   <= '0;
         m1Rdata_q   <= '0;
      end else begin
         m0Ack_q <= 1'b0;
         m1Ack_q <= 1'b0;
         if (capture) begin
            we_q        <= grant1 ? m1_we_i    : m0_we_i;
            addr_q      <= grant1 ? m1_addr_i  : m0_addr_i;
            wdata_q     <= grant1 ? m1_wdata_i : m0_wdata_i;
            lsHB_q      <= grant1 ? m1_lsHB_i  : m0_lsHB_i;
            lU_q        <= grant1 ? m1_lU_i    : m0_lU_i;
            lastGrant_q <= grant1;
         end
         if (state_q == ACC0) begin
            m0Ack_q <= 1'b1;
            if (!we_q) m0Rdata_q <= mem_rdata_i;
         end
         if (state_q == ACC1) begin
            m1Ack_q <= 1'b1;
            if (!we_q) m1Rdata_q <= mem_rdata_i;
         end
      end
   end

   assign mem_rd_o    = (state_q != IDLE) & ~we_q;
   assign mem_wr_o    = (state_q != IDLE) & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_lsHB_o  = lsHB_q;
   assign mem_lU_o    = lU_q;
   assign m0_ack_o    = m0Ack_q;
   assign m1_ack_o    = m1Ack_q;
   assign m0_rdata_o  = m0Rdata_q;
   assign m1_rdata_o  = m1Rdata_q;
   assign cpu_stall_o = m0_req_i & ~m0Ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected acks are queued as requests are driven.
`timescale 1ns/1ps

module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic        m0Req, m0We, m0Lu, m1Req, m1We, m1Lu;
   logic [10:0] m0Addr, m1Addr;
   logic [31:0] m0Wdata, m1Wdata;
   logic [1:0]  m0LsHB, m1LsHB;
   logic        m0Ack, m1Ack, cpuStall, memRd, memWr, memLu;
   logic [31:0] m0Rdata, m1Rdata, memWdata, memRdata;
   logic [10:0] memAddr;
   logic [1:0]  memLsHB;

   logic [31:0] memArr [0:2047];
   logic        pokeEn = 1'b0;
   logic [10:0] pokeAddr;
   logic [31:0] pokeData;

   typedef struct {logic port; logic [31:0] rdata;} exp_t;
   exp_t expQ[$];
   exp_t e;
   int passCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk_i(clk), .rst_ni(rstN),
      .m0_req_i(m0Req), .m0_we_i(m0We), .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata),
      .m0_lsHB_i(m0LsHB), .m0_lU_i(m0Lu), .m0_ack_o(m0Ack), .m0_rdata_o(m0Rdata),
      .m1_req_i(m1Req), .m1_we_i(m1We), .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata),
      .m1_lsHB_i(m1LsHB), .m1_lU_i(m1Lu), .m1_ack_o(m1Ack), .m1_rdata_o(m1Rdata),
      .cpu_stall_o(cpuStall), .mem_rd_o(memRd), .mem_wr_o(memWr), .mem_addr_o(memAddr),
      .mem_wdata_o(memWdata), .mem_lsHB_o(memLsHB), .mem_lU_o(memLu), .mem_rdata_i(memRdata)
   );

   // Memory model: combinational read, write on the rising edge while mem_wr is high.
   assign memRdata = memArr[memAddr];
   always @(posedge clk) begin
      if (memWr) memArr[memAddr] <= memWdata;
      else if (pokeEn) memArr[pokeAddr] <= pokeData;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [10:0] a, input logic [31:0] d);
      pokeAddr = a;
      pokeData = d;
      pokeEn   = 1'b1;
      tick();
      pokeEn   = 1'b0;
   endtask

   task automatic test_reset;
      rstN = 1'b0;
      m0Req = 1'b1; m0We = 1'b0; m0Addr = '0; m0Wdata = '0; m0LsHB = '0; m0Lu = 1'b0;
      m1Req = 1'b0; m1We = 1'b0; m1Addr = '0; m1Wdata = '0; m1LsHB = '0; m1Lu = 1'b0;
      #3;
      checkCount++;
      if ({memRd, memWr, m0Ack, m1Ack} !== 4'b0000 || m0Rdata !== 32'h0 || m1Rdata !== 32'h0)
         $display("[TB] FAIL reset_outputs rd/wr/ack0/ack1=%b rdata0=%h rdata1=%h, required 0000/0/0",
                  {memRd, memWr, m0Ack, m1Ack}, m0Rdata, m1Rdata);
      else passCount++;
      checkCount++;
      if (cpuStall !== 1'b1) $display("[TB] FAIL reset_stall_req1 got %b, required 1", cpuStall);
      else passCount++;
      m0Req = 1'b0;
      #1;
      checkCount++;
      if (cpuStall !== 1'b0) $display("[TB] FAIL reset_stall_req0 got %b, required 0", cpuStall);
      else passCount++;
      m0Req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkCount++;
      if ({memRd, memWr} !== 2'b00) $display("[TB] FAIL reset_no_grant rd/wr=%b, required 00", {memRd, memWr});
      else passCount++;
      m0Req = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      tick();
   endtask

   task automatic test_port0_write;
      m0Req = 1'b1; m0We = 1'b1; m0Addr = 11'h010; m0Wdata = 32'hDEADBEEF; m0LsHB = 2'b10; m0Lu = 1'b0;
      expQ.push_back('{port: 1'b0, rdata: 32'h0});
      @(negedge clk);
      checkCount++;
      if (cpuStall !== 1'b1 || memWr !== 1'b0)
         $display("[TB] FAIL p0w_wait stall=%b wr=%b, required 1/0", cpuStall, memWr);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (memWr !== 1'b1 || memRd !== 1'b0 || memAddr !== 11'h010 || memWdata !== 32'hDEADBEEF ||
          memLsHB !== 2'b10 || cpuStall !== 1'b1)
         $display("[TB] FAIL p0w_strobe wr=%b rd=%b addr=%h data=%h lsHB=%b stall=%b, required 1/0/010/DEADBEEF/10/1",
                  memWr, memRd, memAddr, memWdata, memLsHB, cpuStall);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (m0Ack !== 1'b1 || expQ.size() == 0) begin
         $display("[TB] FAIL p0w_ack ack=%b, required 1", m0Ack);
      end else begin
         e = expQ.pop_front();
         if (m0Rdata !== e.rdata || cpuStall !== 1'b0 || memWr !== 1'b0)
            $display("[TB] FAIL p0w_ack rdata=%h stall=%b wr=%b, required %h/0/0", m0Rdata, cpuStall, memWr, e.rdata);
         else passCount++;
      end
      m0Req = 1'b0;
      tick();
      checkCount++;
      if (memArr[11'h010] !== 32'hDEADBEEF) $display("[TB] FAIL p0w_mem got %h, required DEADBEEF", memArr[11'h010]);
      else passCount++;
   endtask

   task automatic test_port1_access;
      int strobeIdx, ackIdx, m0Seen;
      poke(11'h020, 32'h12345678);
      for (int t = 0; t < 2; t++) begin
         m1Req = 1'b1; m1We = (t == 1); m1Addr = (t == 0) ? 11'h020 : 11'h021;
         m1Wdata = 32'hCAFEF00D; m1LsHB = 2'b01; m1Lu = 1'b1;
         expQ.push_back('{port: 1'b1, rdata: 32'h12345678});
         strobeIdx = 0; ackIdx = 0; m0Seen = 0;
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (m0Ack) m0Seen++;
            if (memRd | memWr) begin
               strobeIdx = c;
               checkCount++;
               if (memRd !== (t == 0) || memAddr !== m1Addr || memLsHB !== 2'b01 || memLu !== 1'b1)
                  $display("[TB] FAIL p1_strobe%0d rd=%b addr=%h lsHB=%b lU=%b, required rd=%b addr=%h 01/1",
                           t, memRd, memAddr, memLsHB, memLu, (t == 0), m1Addr);
               else passCount++;
            end
            if (m1Ack) begin
               ackIdx = c;
               m1Req = 1'b0;
               checkCount++;
               if (expQ.size() == 0) $display("[TB] FAIL p1_ack%0d unexpected ack", t);
               else begin
                  e = expQ.pop_front();
                  if (m1Rdata !== e.rdata) $display("[TB] FAIL p1_rdata%0d got %h, required %h", t, m1Rdata, e.rdata);
                  else passCount++;
               end
            end
         end
         checkCount++;
         if (strobeIdx != 2 || ackIdx != 3 || m0Seen != 0)
            $display("[TB] FAIL p1_timing%0d strobe@%0d ack@%0d m0acks=%0d, required 2/3/0", t, strobeIdx, ackIdx, m0Seen);
         else passCount++;
         m1Req = 1'b0;
         tick();
      end
   endtask

   task automatic test_both_held;
      int acks;
      poke(11'h030, 32'hA0A0A0A0);
      poke(11'h040, 32'hB0B0B0B0);
      m0Req = 1'b1; m0We = 1'b0; m0Addr = 11'h030;
      m1Req = 1'b1; m1We = 1'b0; m1Addr = 11'h040;
      for (int i = 0; i < 2; i++) begin
         expQ.push_back('{port: 1'b0, rdata: 32'hA0A0A0A0});
         expQ.push_back('{port: 1'b1, rdata: 32'hB0B0B0B0});
      end
      acks = 0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (m0Ack | m1Ack) begin
            acks++;
            checkCount++;
            if (expQ.size() == 0) $display("[TB] FAIL both_ack unexpected ack port=%0d", m1Ack);
            else begin
               e = expQ.pop_front();
               if (m1Ack !== e.port || (m1Ack ? m1Rdata : m0Rdata) !== e.rdata)
                  $display("[TB] FAIL both_ack%0d port=%0d rdata=%h, required port=%0d rdata=%h",
                           acks, m1Ack, (m1Ack ? m1Rdata : m0Rdata), e.port, e.rdata);
               else passCount++;
            end
         end
      end
      m0Req = 1'b0; m1Req = 1'b0;
      checkCount++;
      if (acks != 4 || expQ.size() != 0) $display("[TB] FAIL both_count acks=%0d left=%0d, required 4/0", acks, expQ.size());
      else passCount++;
      expQ.delete();
      tick();
   endtask

   task automatic test_tie_policy;
      int acks;
      m0Req = 1'b1; m0We = 1'b0; m0Addr = 11'h030;
      for (int c = 0; c < 6 && !m0Ack; c++) @(negedge clk);
      m0Req = 1'b0;
      tick();
      m0Req = 1'b1; m1Req = 1'b1; m1We = 1'b0; m1Addr = 11'h040;
`ifdef DMEM_ARB_RR_EN
      expQ.push_back('{port: 1'b1, rdata: 32'hB0B0B0B0});
      expQ.push_back('{port: 1'b0, rdata: 32'hA0A0A0A0});
`else
      expQ.push_back('{port: 1'b0, rdata: 32'hA0A0A0A0});
      expQ.push_back('{port: 1'b1, rdata: 32'hB0B0B0B0});
`endif
      acks = 0;
      for (int c = 0; c < 8 && acks < 2; c++) begin
         @(negedge clk);
         if (m0Ack | m1Ack) begin
            acks++;
            checkCount++;
            if (expQ.size() == 0) $display("[TB] FAIL tie_ack unexpected ack port=%0d", m1Ack);
            else begin
               e = expQ.pop_front();
               if (m1Ack !== e.port || (m1Ack ? m1Rdata : m0Rdata) !== e.rdata)
                  $display("[TB] FAIL tie_ack%0d port=%0d rdata=%h, required port=%0d rdata=%h",
                           acks, m1Ack, (m1Ack ? m1Rdata : m0Rdata), e.port, e.rdata);
               else passCount++;
            end
            if (m0Ack) m0Req = 1'b0;
            if (m1Ack) m1Req = 1'b0;
         end
      end
      checkCount++;
      if (acks != 2) $display("[TB] FAIL tie_count acks=%0d, required 2", acks);
      else passCount++;
      m0Req = 1'b0; m1Req = 1'b0;
      expQ.delete();
      tick();
   endtask

   task automatic test_drop_cases;
      int activity;
      m0Req = 1'b1; m0We = 1'b1; m0Addr = 11'h070; m0Wdata = 32'h77777777;
      @(negedge clk);
      m0Req = 1'b0;
      activity = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (memRd | memWr | m0Ack | m1Ack) activity++;
      end
      checkCount++;
      if (activity != 0) $display("[TB] FAIL drop_before_grant activity=%0d, required 0", activity);
      else passCount++;
      tick();
      m1Req = 1'b1; m1We = 1'b1; m1Addr = 11'h050; m1Wdata = 32'h55AA55AA;
      expQ.push_back('{port: 1'b1, rdata: 32'hB0B0B0B0});
      @(negedge clk);
      @(negedge clk);
      checkCount++;
      if (memWr !== 1'b1 || memAddr !== 11'h050) $display("[TB] FAIL drop_acc_strobe wr=%b addr=%h, required 1/050", memWr, memAddr);
      else passCount++;
      m1Req = 1'b0; m1Addr = 11'h051; m1Wdata = 32'h0; m1We = 1'b0;
      @(negedge clk);
      checkCount++;
      if (m1Ack !== 1'b1 || expQ.size() == 0) $display("[TB] FAIL drop_acc_ack ack=%b, required 1", m1Ack);
      else begin
         e = expQ.pop_front();
         if (m1Rdata !== e.rdata || memArr[11'h050] !== 32'h55AA55AA)
            $display("[TB] FAIL drop_acc_data rdata=%h mem=%h, required %h/55AA55AA", m1Rdata, memArr[11'h050], e.rdata);
         else passCount++;
      end
      expQ.delete();
      tick();
   endtask

   task automatic test_back_to_back;
      int acks, strobes, lastAck, minGap;
      logic [10:0] addrList [3];
      addrList[0] = 11'h100; addrList[1] = 11'h101; addrList[2] = 11'h102;
      m0Req = 1'b1; m0We = 1'b1; m0Addr = addrList[0]; m0Wdata = 32'h1000;
      for (int i = 0; i < 3; i++) expQ.push_back('{port: 1'b0, rdata: 32'hA0A0A0A0});
      acks = 0; strobes = 0; lastAck = 0; minGap = 99;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (memWr | memRd) begin
            checkCount++;
            if (strobes > 2 || memAddr !== addrList[strobes])
               $display("[TB] FAIL b2b_strobe%0d addr=%h, required %h", strobes, memAddr, addrList[strobes % 3]);
            else passCount++;
            strobes++;
         end
         if (m0Ack | m1Ack) begin
            checkCount++;
            if (expQ.size() == 0 || m1Ack) $display("[TB] FAIL b2b_ack unexpected ack port=%0d", m1Ack);
            else begin
               e = expQ.pop_front();
               if (m0Rdata !== e.rdata) $display("[TB] FAIL b2b_rdata got %h, required %h", m0Rdata, e.rdata);
               else passCount++;
            end
            if (acks > 0 && (c - lastAck) < minGap) minGap = c - lastAck;
            lastAck = c;
            acks++;
            if (acks < 3) begin
               m0Addr = addrList[acks];
               m0Wdata = 32'h1000 + acks;
            end else m0Req = 1'b0;
         end
      end
      checkCount++;
      if (acks != 3 || strobes != 3 || minGap < 2 || memArr[11'h102] !== 32'h1002)
         $display("[TB] FAIL b2b_summary acks=%0d strobes=%0d mingap=%0d mem102=%h, required 3/3/>=2/00001002",
                  acks, strobes, minGap, memArr[11'h102]);
      else passCount++;
      m0Req = 1'b0;
      expQ.delete();
      tick();
   endtask

   task automatic test_reset_mid_acc;
      int badAck, acks;
      poke(11'h060, 32'h0);
      m1Req = 1'b1; m1We = 1'b1; m1Addr = 11'h060; m1Wdata = 32'h66666666;
      @(negedge clk);
      @(negedge clk);
      checkCount++;
      if (memWr !== 1'b1) $display("[TB] FAIL rst_acc_pre wr=%b, required 1", memWr);
      else passCount++;
      #1 rstN = 1'b0;
      #1;
      checkCount++;
      if ({memWr, memRd} !== 2'b00) $display("[TB] FAIL rst_acc_async wr/rd=%b, required 00", {memWr, memRd});
      else passCount++;
      m1Req = 1'b0;
      badAck = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (m1Ack | m0Ack) badAck++;
      end
      rstN = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (m1Ack | m0Ack) badAck++;
      end
      checkCount++;
      if (badAck != 0 || memArr[11'h060] !== 32'h0)
         $display("[TB] FAIL rst_acc_noack acks=%0d mem060=%h, required 0/00000000", badAck, memArr[11'h060]);
      else passCount++;
      tick();
      m0Req = 1'b1; m0We = 1'b0; m0Addr = 11'h030;
      m1Req = 1'b1; m1We = 1'b0; m1Addr = 11'h040;
      expQ.push_back('{port: 1'b0, rdata: 32'hA0A0A0A0});
      expQ.push_back('{port: 1'b1, rdata: 32'hB0B0B0B0});
      acks = 0;
      for (int c = 0; c < 8 && acks < 2; c++) begin
         @(negedge clk);
         if (m0Ack | m1Ack) begin
            acks++;
            checkCount++;
            if (expQ.size() == 0) $display("[TB] FAIL rst_tie unexpected ack port=%0d", m1Ack);
            else begin
               e = expQ.pop_front();
               if (m1Ack !== e.port || (m1Ack ? m1Rdata : m0Rdata) !== e.rdata)
                  $display("[TB] FAIL rst_tie_ack%0d port=%0d rdata=%h, required port=%0d rdata=%h",
                           acks, m1Ack, (m1Ack ? m1Rdata : m0Rdata), e.port, e.rdata);
               else passCount++;
            end
            if (m0Ack) m0Req = 1'b0;
            if (m1Ack) m1Req = 1'b0;
         end
      end
      checkCount++;
      if (acks != 2) $display("[TB] FAIL rst_tie_count acks=%0d, required 2", acks);
      else passCount++;
      m0Req = 1'b0; m1Req = 1'b0;
      expQ.delete();
      tick();
   endtask

   initial begin
      test_reset();
      test_port0_write();
      test_port1_access();
      test_both_held();
      test_tie_policy();
      test_drop_cases();
      test_back_to_back();
      test_reset_mid_acc();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation time limit reached, passed=%0d of %0d", passCount, checkCount);
      $fatal(1, "[TB] watchdog");
   end

endmodule
